// File: rtl/packing_controller.sv
// packing_controller: sequences the compressor pack/shift datapath and emits 128-bit beats.
// Optional build macro PACK_CTRL_STATS_EN adds saturating line/stop counters (o_line_cnt, o_stop_cnt).
module packing_controller #(
    parameter int PACK_WIDTH = 136,
    parameter int CHUNK      = 64,
    parameter int BEAT_WIDTH = 128,
    parameter int LINE_BITS  = 512,
    parameter int LEN_W      = 6,
    parameter int TOT_W      = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [LEN_W-1:0] i_len1,
    input  logic [LEN_W-1:0] i_len2,
    input  logic             i_last,
    output logic [LEN_W-1:0] o_word2_length,
    output logic [6:0]       o_total_length,
    output logic [6:0]       o_out_shift,
    output logic             o_store_flag,
    output logic             o_push_flag,
    output logic             o_fill_flag,
    output logic             o_output_flag,
    output logic             o_stop_flag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_line_done
`ifdef PACK_CTRL_STATS_EN
    ,
    output logic [15:0]      o_line_cnt,
    output logic [15:0]      o_stop_cnt
`endif
);
    localparam int ACC_W = $clog2(PACK_WIDTH);
    localparam int BEATS = LINE_BITS / BEAT_WIDTH;
    localparam int BT_W  = $clog2(BEATS + 1);

    typedef enum logic [2:0] {ACCUM, DRAIN, FLUSH, EMIT, STOP} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_add, acc_sub;
    logic [TOT_W-1:0]  tot_q, tot_d, tot_add;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [BT_W-1:0]   beat_q, beat_d;
    logic [6:0]        len;

    assign len            = 7'(i_len1) + 7'(i_len2);
    assign acc_add        = acc_q + ACC_W'(len);
    assign acc_sub        = acc_q - ACC_W'(CHUNK);
    assign tot_add        = tot_q + TOT_W'(len);
    assign o_word2_length = i_len1;
    assign o_total_length = len;

    // State and bookkeeping registers; reset leaves the controller idle and ready.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            tot_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tot_q   <= tot_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and flag decode; a beat holds two stored chunks, a stopped line emits raw beats.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        tot_d         = tot_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        beat_d        = beat_q;
        o_ready       = 1'b0;
        o_out_shift   = '0;
        o_store_flag  = 1'b0;
        o_push_flag   = 1'b0;
        o_fill_flag   = 1'b0;
        o_output_flag = 1'b0;
        o_stop_flag   = 1'b0;
        o_out_valid   = 1'b0;
        o_line_done   = 1'b0;
        case (state_q)
            ACCUM: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    acc_d   = acc_add;
                    tot_d   = tot_add;
                    last_d  = last_q | i_last;
                    state_d = tot_add > TOT_W'(LINE_BITS) ? STOP :
                              acc_add >= ACC_W'(CHUNK)    ? DRAIN :
                              (last_q | i_last)           ? FLUSH : ACCUM;
                end
            end
            DRAIN: begin
                o_store_flag = 1'b1;
                o_out_shift  = 7'(acc_sub);
                acc_d        = acc_sub;
                cnt_d        = cnt_q + 2'd1;
                state_d      = cnt_q == 2'd1              ? EMIT :
                               acc_sub >= ACC_W'(CHUNK)   ? DRAIN :
                               last_q                     ? FLUSH : ACCUM;
            end
            FLUSH: begin
                if (acc_q != '0) begin
                    o_push_flag  = 1'b1;
                    o_store_flag = 1'b1;
                    o_fill_flag  = 1'b1;
                    acc_d        = '0;
                    cnt_d        = cnt_q + 2'd1;
                    state_d      = EMIT;
                end else if (cnt_q != '0) begin
                    state_d = EMIT;
                end else begin
                    o_line_done = 1'b1;
                    tot_d       = '0;
                    last_d      = 1'b0;
                    state_d     = ACCUM;
                end
            end
            EMIT: begin
                o_output_flag = 1'b1;
                o_out_valid   = 1'b1;
                if (i_out_ready) begin
                    cnt_d = '0;
                    if (acc_q >= ACC_W'(CHUNK)) begin
                        state_d = DRAIN;
                    end else if (last_q && acc_q != '0) begin
                        state_d = FLUSH;
                    end else begin
                        o_line_done = last_q;
                        tot_d       = last_q ? '0 : tot_q;
                        last_d      = 1'b0;
                        state_d     = ACCUM;
                    end
                end
            end
            STOP: begin
                o_stop_flag = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                o_ready     = !last_q;
                o_out_valid = last_q;
                if (!last_q) begin
                    last_d = i_valid & i_last;
                end else if (i_out_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BT_W'(BEATS - 1)) begin
                        o_line_done = 1'b1;
                        beat_d      = '0;
                        tot_d       = '0;
                        last_d      = 1'b0;
                        state_d     = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

`ifdef PACK_CTRL_STATS_EN
    logic [15:0] line_cnt_q, stop_cnt_q;

    // Saturating counters of finished lines and of lines sent raw.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            line_cnt_q <= '0;
            stop_cnt_q <= '0;
        end else begin
            if (o_line_done && line_cnt_q != 16'hFFFF)
                line_cnt_q <= line_cnt_q + 16'd1;
            if (o_line_done && state_q == STOP && stop_cnt_q != 16'hFFFF)
                stop_cnt_q <= stop_cnt_q + 16'd1;
        end
    end

    assign o_line_cnt = line_cnt_q;
    assign o_stop_cnt = stop_cnt_q;
`endif
endmodule
